// File: rtl/hash16_pkg.sv
// Shared constants, packer state encoding and M3 packing rule for the 16-bit hashing path.
package hash16_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_BYTES = 6;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    HOLD
  } packer_state_e;

  // M3 carries the non-zero byte count in its low bits.
  function automatic logic [WORD_W-1:0] pack_m3(input logic [2:0] cnt);
    return {13'b0, cnt};
  endfunction

endpackage

// File: rtl/msg_block_packer.sv
// Collects up to six bytes of a message into a held block of four 16-bit words.
// Short messages are zero-padded; bytes past the sixth are discarded and flagged.
module msg_block_packer #(
  parameter int unsigned BLOCK_BYTES = 6,
  parameter int unsigned CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_m0,
  output logic [15:0] out_m1,
  output logic [15:0] out_m2,
  output logic [15:0] out_m3,
  output logic        out_trunc
);

  import hash16_pkg::*;

  localparam logic [2:0] LastIdx = 3'(BLOCK_BYTES - 1);

  packer_state_e    r_state;
  packer_state_e    w_state_next;
  logic [7:0]       r_slot [BLOCK_BYTES];
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_trunc;

  logic w_accept;
  logic w_filling;
  logic w_release;
  logic w_nonzero;

  assign in_ready  = (r_state != HOLD);
  assign out_valid = (r_state == HOLD);

  assign w_accept  = in_valid && in_ready;
  // Bytes are kept only while slots remain; DRAIN swallows the overflow.
  assign w_filling = w_accept && ((r_state == IDLE) || (r_state == COLLECT));
  assign w_release = out_valid && out_ready;
  assign w_nonzero = (in_byte != 8'h00);

  // Next-state decode for the collect/drain/hold sequence.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (w_accept) begin
          if (in_last)                 w_state_next = HOLD;
          else if (r_idx == LastIdx)   w_state_next = DRAIN;
          else                         w_state_next = COLLECT;
        end
      end
      DRAIN: begin
        if (w_accept && in_last) w_state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Slot fill, non-zero count and truncation flag; all cleared when the block is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_BYTES; i++) r_slot[i] <= 8'h00;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else if (w_release) begin
      for (int i = 0; i < BLOCK_BYTES; i++) r_slot[i] <= 8'h00;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else if (w_filling) begin
      r_slot[r_idx] <= in_byte;
      r_idx         <= r_idx + 3'd1;
      r_cnt         <= r_cnt + {{(CNT_W-1){1'b0}}, w_nonzero};
      if ((r_idx == LastIdx) && !in_last) r_trunc <= 1'b1;
    end
  end

  assign out_m0    = {r_slot[0], r_slot[1]};
  assign out_m1    = {r_slot[2], r_slot[3]};
  assign out_m2    = {r_slot[4], r_slot[5]};
  assign out_m3    = pack_m3(r_cnt);
  assign out_trunc = r_trunc;

endmodule

// File: tb/tb_msg_block_packer.sv
// Directed bench for msg_block_packer: full, short, overlong, backpressure and reset cases.
module tb_msg_block_packer;

  import hash16_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_byte;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_m0;
  logic [WORD_W-1:0] out_m1;
  logic [WORD_W-1:0] out_m2;
  logic [WORD_W-1:0] out_m3;
  logic              out_trunc;

  int n_checks;
  int n_fail;

  msg_block_packer #(
    .BLOCK_BYTES(6),
    .CNT_W      (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_m0   (out_m0),
    .out_m1   (out_m1),
    .out_m2   (out_m2),
    .out_m3   (out_m3),
    .out_trunc(out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat at the falling edge; the next rising edge may accept it.
  task automatic drive(input logic [7:0] b, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = l;
  endtask

  // Drop in_valid at the next falling edge, after the previous beat's rising edge.
  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = 8'h00;
  endtask

  // Consume the held block and confirm the packer reopens with cleared words.
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_hs_valid: got %b expected 0", tag, out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_hs_ready: got %b expected 1", tag, in_ready); end
    n_checks++; if (out_m0 !== 16'h0000) begin n_fail++; $display("FAIL %s_hs_m0: got %h expected 0000", tag, out_m0); end
    n_checks++; if (out_m3 !== 16'h0000) begin n_fail++; $display("FAIL %s_hs_m3: got %h expected 0000", tag, out_m3); end
    n_checks++; if (out_trunc !== 1'b0) begin n_fail++; $display("FAIL %s_hs_trunc: got %b expected 0", tag, out_trunc); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if ({out_m0, out_m1, out_m2, out_m3} !== 64'h0) begin n_fail++; $display("FAIL rst_words: got %h expected 0", {out_m0, out_m1, out_m2, out_m3}); end
    n_checks++; if (out_trunc !== 1'b0) begin n_fail++; $display("FAIL rst_trunc: got %b expected 0", out_trunc); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_block();
    drive(8'h41, 1'b0); drive(8'h42, 1'b0); drive(8'h43, 1'b0);
    drive(8'h44, 1'b0); drive(8'h45, 1'b0); drive(8'h46, 1'b1);
    idle_in();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b expected 1", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_m0 !== 16'h4142) begin n_fail++; $display("FAIL full_m0: got %h expected 4142", out_m0); end
    n_checks++; if (out_m1 !== 16'h4344) begin n_fail++; $display("FAIL full_m1: got %h expected 4344", out_m1); end
    n_checks++; if (out_m2 !== 16'h4546) begin n_fail++; $display("FAIL full_m2: got %h expected 4546", out_m2); end
    n_checks++; if (out_m3 !== 16'h0006) begin n_fail++; $display("FAIL full_m3: got %h expected 0006", out_m3); end
    n_checks++; if (out_trunc !== 1'b0) begin n_fail++; $display("FAIL full_trunc: got %b expected 0", out_trunc); end
    handshake("full");
  endtask

  task automatic test_short_zero();
    drive(8'h41, 1'b0); drive(8'h00, 1'b0); drive(8'h42, 1'b1);
    idle_in();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_m0 !== 16'h4100) begin n_fail++; $display("FAIL short_m0: got %h expected 4100", out_m0); end
    n_checks++; if (out_m1 !== 16'h4200) begin n_fail++; $display("FAIL short_m1: got %h expected 4200", out_m1); end
    n_checks++; if (out_m2 !== 16'h0000) begin n_fail++; $display("FAIL short_m2: got %h expected 0000", out_m2); end
    n_checks++; if (out_m3 !== 16'h0002) begin n_fail++; $display("FAIL short_m3: got %h expected 0002", out_m3); end
    handshake("short");
  endtask

  task automatic test_zero_last();
    drive(8'h05, 1'b0); drive(8'h00, 1'b1);
    idle_in();
    n_checks++; if (out_m0 !== 16'h0500) begin n_fail++; $display("FAIL zlast_m0: got %h expected 0500", out_m0); end
    n_checks++; if (out_m3 !== 16'h0001) begin n_fail++; $display("FAIL zlast_m3: got %h expected 0001", out_m3); end
    handshake("zlast");
  endtask

  task automatic test_overlong();
    for (int i = 1; i <= 8; i++) begin
      drive(8'(i), (i == 8));
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL long_ready_beat%0d: got %b expected 1", i, in_ready); end
    end
    idle_in();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL long_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_m0 !== 16'h0102) begin n_fail++; $display("FAIL long_m0: got %h expected 0102", out_m0); end
    n_checks++; if (out_m1 !== 16'h0304) begin n_fail++; $display("FAIL long_m1: got %h expected 0304", out_m1); end
    n_checks++; if (out_m2 !== 16'h0506) begin n_fail++; $display("FAIL long_m2: got %h expected 0506", out_m2); end
    n_checks++; if (out_m3 !== 16'h0006) begin n_fail++; $display("FAIL long_m3: got %h expected 0006", out_m3); end
    n_checks++; if (out_trunc !== 1'b1) begin n_fail++; $display("FAIL long_trunc: got %b expected 1", out_trunc); end
    handshake("long");
  endtask

  task automatic test_backpressure();
    drive(8'hAA, 1'b1);
    // Byte 77 is offered continuously while the block is held.
    drive(8'h77, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b expected 1", c, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b expected 0", c, in_ready); end
      n_checks++; if (out_m0 !== 16'hAA00 || out_m3 !== 16'h0001) begin n_fail++; $display("FAIL bp_hold_c%0d: got %h/%h expected AA00/0001", c, out_m0, out_m3); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_rel_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rel_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_m0 !== 16'h0000) begin n_fail++; $display("FAIL bp_no_bypass: got %h expected 0000", out_m0); end
    idle_in();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_m0 !== 16'h7700) begin n_fail++; $display("FAIL bp_next_m0: got %h expected 7700", out_m0); end
    n_checks++; if (out_m3 !== 16'h0001) begin n_fail++; $display("FAIL bp_next_m3: got %h expected 0001", out_m3); end
    handshake("bp");
  endtask

  task automatic test_reset_mid();
    drive(8'h11, 1'b0); drive(8'h22, 1'b0); drive(8'h33, 1'b0);
    idle_in();
    rst = 1'b1;
    #1;
    n_checks++; if ({out_m0, out_m1, out_m2, out_m3} !== 64'h0) begin n_fail++; $display("FAIL mid_rst_words: got %h expected 0", {out_m0, out_m1, out_m2, out_m3}); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    drive(8'hFF, 1'b1);
    idle_in();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_m0 !== 16'hFF00) begin n_fail++; $display("FAIL mid_m0: got %h expected FF00", out_m0); end
    n_checks++; if (out_m1 !== 16'h0000 || out_m2 !== 16'h0000) begin n_fail++; $display("FAIL mid_m1m2: got %h/%h expected 0000/0000", out_m1, out_m2); end
    n_checks++; if (out_m3 !== 16'h0001) begin n_fail++; $display("FAIL mid_m3: got %h expected 0001", out_m3); end
    n_checks++; if (out_trunc !== 1'b0) begin n_fail++; $display("FAIL mid_trunc: got %b expected 0", out_trunc); end
    handshake("mid");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_full_block();
    test_short_zero();
    test_zero_last();
    test_overlong();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
